// File: rtl/scr1_dmem_slice.sv
// Memory-interface types shared by the dmem slice and anything attached to it.
package scr1_memif_pkg;

    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

// Single-entry request slice between the core dmem port and the dmem router.
// The request is always registered; the response can optionally be registered
// too (SCR1_SLICE_RESP_REG=1) at the cost of one extra cycle.
module scr1_dmem_slice
    import scr1_memif_pkg::*;
#(
    parameter bit SCR1_SLICE_RESP_REG = 1'b0
) (
    input  logic                        rst_n,
    input  logic                        clk,

    output logic                        core_req_ack,
    input  logic                        core_req,
    input  type_scr1_mem_cmd_e          core_cmd,
    input  type_scr1_mem_width_e        core_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] core_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] core_wdata,
    output logic [SCR1_DMEM_DWIDTH-1:0] core_rdata,
    output type_scr1_mem_resp_e         core_resp,

    input  logic                        rtr_req_ack,
    output logic                        rtr_req,
    output type_scr1_mem_cmd_e          rtr_cmd,
    output type_scr1_mem_width_e        rtr_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] rtr_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] rtr_wdata,
    input  logic [SCR1_DMEM_DWIDTH-1:0] rtr_rdata,
    input  type_scr1_mem_resp_e         rtr_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RSP  = 2'b11
    } state_e;

    state_e                      state_reg;
    state_e                      state_next;
    logic                        req_accept;
    logic                        rsp_capture;
    type_scr1_mem_resp_e         resp_r;
    logic [SCR1_DMEM_DWIDTH-1:0] rdata_r;

    // A request is taken from the core whenever it is offered while we acknowledge.
    assign req_accept = core_req & core_req_ack;

    // The router request is simply "holding an un-acked request".
    assign rtr_req = (state_reg == ST_REQ);

    // State register; reset drops rtr_req immediately since it decodes from state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request fields are captured on accept and held stable until the router acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtr_cmd   <= SCR1_MEM_CMD_RD;
            rtr_width <= SCR1_MEM_WIDTH_WORD;
            rtr_addr  <= '0;
            rtr_wdata <= '0;
        end else if (req_accept) begin
            rtr_cmd   <= core_cmd;
            rtr_width <= core_width;
            rtr_addr  <= core_addr;
            rtr_wdata <= core_wdata;
        end
    end

    // Response holding registers, only loaded in registered-response mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r  <= SCR1_MEM_RESP_NOTRDY;
            rdata_r <= '0;
        end else if (rsp_capture) begin
            resp_r  <= rtr_resp;
            rdata_r <= rtr_rdata;
        end
    end

    // Next-state and core-side handshake; core_req_ack never depends on rtr_req_ack.
    always_comb begin
        state_next   = state_reg;
        core_req_ack = 1'b0;
        core_resp    = SCR1_MEM_RESP_NOTRDY;
        rsp_capture  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                core_req_ack = 1'b1;
                if (core_req) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rtr_req_ack) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (SCR1_SLICE_RESP_REG) begin
                    // Park the response in flops; the core sees it next cycle.
                    if (rtr_resp != SCR1_MEM_RESP_NOTRDY) begin
                        rsp_capture = 1'b1;
                        state_next  = ST_RSP;
                    end
                end else begin
                    core_resp    = rtr_resp;
                    core_req_ack = (rtr_resp == SCR1_MEM_RESP_RDY_OK);
                    if (rtr_resp != SCR1_MEM_RESP_NOTRDY) begin
                        // Errors never accept a new request in the same cycle.
                        state_next = (core_req && (rtr_resp == SCR1_MEM_RESP_RDY_OK)) ? ST_REQ : ST_IDLE;
                    end
                end
            end
            ST_RSP: begin
                core_resp    = resp_r;
                core_req_ack = (resp_r == SCR1_MEM_RESP_RDY_OK);
                state_next   = (core_req && (resp_r == SCR1_MEM_RESP_RDY_OK)) ? ST_REQ : ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Read data source follows the response path; poisoned when no response is valid.
    always_comb begin
        core_rdata = SCR1_SLICE_RESP_REG ? rdata_r : rtr_rdata;
`ifdef SCR1_XPROP_EN
        if (core_resp == SCR1_MEM_RESP_NOTRDY) begin
            core_rdata = 'x;
        end
`endif
    end

`ifdef SCR1_TRGT_SIMULATION
    a_core_req_known: assert property (@(posedge clk) disable iff (!rst_n)
        core_req |-> !$isunknown({core_cmd, core_width}));

    a_rtr_fields_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rtr_req && !rtr_req_ack) |=> ($stable(rtr_cmd) && $stable(rtr_width)
                                       && $stable(rtr_addr) && $stable(rtr_wdata)));
`endif

endmodule

// File: tb/tb_scr1_dmem_slice.sv
// Bench for scr1_dmem_slice: instance 0 runs with a pass-through response,
// instance 1 with a registered response. A transaction-level model checks both
// every cycle; directed scenarios add hand-computed literal checks.
module tb_scr1_dmem_slice;
    import scr1_memif_pkg::*;

    localparam type_scr1_mem_resp_e NR = SCR1_MEM_RESP_NOTRDY;
    localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
    localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;

    logic clk = 1'b0;
    logic rst_n;

    logic                 core_req_ack [2];
    logic                 core_req     [2];
    type_scr1_mem_cmd_e   core_cmd     [2];
    type_scr1_mem_width_e core_width   [2];
    logic [31:0]          core_addr    [2];
    logic [31:0]          core_wdata   [2];
    logic [31:0]          core_rdata   [2];
    type_scr1_mem_resp_e  core_resp    [2];
    logic                 rtr_req_ack  [2];
    logic                 rtr_req      [2];
    type_scr1_mem_cmd_e   rtr_cmd      [2];
    type_scr1_mem_width_e rtr_width    [2];
    logic [31:0]          rtr_addr     [2];
    logic [31:0]          rtr_wdata    [2];
    logic [31:0]          rtr_rdata    [2];
    type_scr1_mem_resp_e  rtr_resp     [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    scr1_dmem_slice #(.SCR1_SLICE_RESP_REG(1'b0)) dut0 (
        .rst_n(rst_n), .clk(clk),
        .core_req_ack(core_req_ack[0]), .core_req(core_req[0]), .core_cmd(core_cmd[0]),
        .core_width(core_width[0]), .core_addr(core_addr[0]), .core_wdata(core_wdata[0]),
        .core_rdata(core_rdata[0]), .core_resp(core_resp[0]),
        .rtr_req_ack(rtr_req_ack[0]), .rtr_req(rtr_req[0]), .rtr_cmd(rtr_cmd[0]),
        .rtr_width(rtr_width[0]), .rtr_addr(rtr_addr[0]), .rtr_wdata(rtr_wdata[0]),
        .rtr_rdata(rtr_rdata[0]), .rtr_resp(rtr_resp[0])
    );

    scr1_dmem_slice #(.SCR1_SLICE_RESP_REG(1'b1)) dut1 (
        .rst_n(rst_n), .clk(clk),
        .core_req_ack(core_req_ack[1]), .core_req(core_req[1]), .core_cmd(core_cmd[1]),
        .core_width(core_width[1]), .core_addr(core_addr[1]), .core_wdata(core_wdata[1]),
        .core_rdata(core_rdata[1]), .core_resp(core_resp[1]),
        .rtr_req_ack(rtr_req_ack[1]), .rtr_req(rtr_req[1]), .rtr_cmd(rtr_cmd[1]),
        .rtr_width(rtr_width[1]), .rtr_addr(rtr_addr[1]), .rtr_wdata(rtr_wdata[1]),
        .rtr_rdata(rtr_rdata[1]), .rtr_resp(rtr_resp[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs(input int d);
        core_req[d]    = 1'b0;
        core_cmd[d]    = SCR1_MEM_CMD_RD;
        core_width[d]  = SCR1_MEM_WIDTH_WORD;
        core_addr[d]   = '0;
        core_wdata[d]  = '0;
        rtr_req_ack[d] = 1'b0;
        rtr_rdata[d]   = '0;
        rtr_resp[d]    = NR;
    endtask

    task automatic offer(input int d, input type_scr1_mem_cmd_e c, input logic [31:0] a,
                         input logic [31:0] w);
        core_req[d]   = 1'b1;
        core_cmd[d]   = c;
        core_width[d] = SCR1_MEM_WIDTH_WORD;
        core_addr[d]  = a;
        core_wdata[d] = w;
    endtask

    // Transaction-level model: a held (un-acked) request, an in-flight request,
    // and for the registered mode a one-cycle presentation of the stored response.
    initial begin : model
        logic                 held [2];
        logic                 infl [2];
        logic                 rv   [2];
        type_scr1_mem_cmd_e   mcmd [2];
        type_scr1_mem_width_e mwid [2];
        logic [31:0]          maddr [2];
        logic [31:0]          mwd   [2];
        logic [31:0]          mrd   [2];
        type_scr1_mem_resp_e  mresp [2];
        type_scr1_mem_resp_e  eresp;
        logic                 eack;
        logic [31:0]          erd;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n !== 1'b1) begin
                    held[d] = 1'b0; infl[d] = 1'b0; rv[d] = 1'b0;
                    mcmd[d] = SCR1_MEM_CMD_RD; mwid[d] = SCR1_MEM_WIDTH_WORD;
                    maddr[d] = '0; mwd[d] = '0; mrd[d] = '0; mresp[d] = NR;
                end
                eresp = NR;
                erd   = '0;
                if (d == 0) begin
                    eack = !held[d];
                    if (infl[d]) begin
                        eresp = rtr_resp[d];
                        eack  = (rtr_resp[d] == OK);
                        erd   = rtr_rdata[d];
                    end
                end else begin
                    eack = !held[d] && !infl[d];
                    if (rv[d]) begin
                        eresp = mresp[d];
                        eack  = (mresp[d] == OK);
                        erd   = mrd[d];
                    end
                end
                chk($sformatf("m%0d_rtr_req", d), 32'(rtr_req[d]), 32'(held[d]));
                chk($sformatf("m%0d_rtr_cmd", d), 32'(rtr_cmd[d]), 32'(mcmd[d]));
                chk($sformatf("m%0d_rtr_width", d), 32'(rtr_width[d]), 32'(mwid[d]));
                chk($sformatf("m%0d_rtr_addr", d), rtr_addr[d], maddr[d]);
                chk($sformatf("m%0d_rtr_wdata", d), rtr_wdata[d], mwd[d]);
                chk($sformatf("m%0d_core_resp", d), 32'(core_resp[d]), 32'(eresp));
                chk($sformatf("m%0d_core_req_ack", d), 32'(core_req_ack[d]), 32'(eack));
                if (eresp != NR) begin
                    chk($sformatf("m%0d_core_rdata", d), core_rdata[d], erd);
                    $display("dut%0d t=%0t response %0d rdata %h", d, $time, eresp, core_rdata[d]);
                end
                if (rst_n === 1'b1) begin
                    rv[d] = 1'b0;
                    if (infl[d] && rtr_resp[d] != NR) begin
                        infl[d] = 1'b0;
                        if (d == 1) begin
                            rv[d] = 1'b1; mresp[d] = rtr_resp[d]; mrd[d] = rtr_rdata[d];
                        end
                    end
                    if (held[d] && rtr_req_ack[d]) begin
                        held[d] = 1'b0; infl[d] = 1'b1;
                    end
                    if (core_req[d] && eack) begin
                        held[d] = 1'b1; mcmd[d] = core_cmd[d]; mwid[d] = core_width[d];
                        maddr[d] = core_addr[d]; mwd[d] = core_wdata[d];
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        idle_inputs(0);
        idle_inputs(1);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rtr_req", 32'(rtr_req[d]), 32'd0);
            chk("rst_core_resp", 32'(core_resp[d]), 32'(NR));
            chk("rst_core_req_ack", 32'(core_req_ack[d]), 32'd1);
            chk("rst_rtr_width", 32'(rtr_width[d]), 32'(SCR1_MEM_WIDTH_WORD));
        end
        rst_n = 1'b1;

        // Single read, pass-through response
        tick(); offer(0, SCR1_MEM_CMD_RD, 32'h0001_0004, 32'h0);
        #1 chk("s1_accept", 32'(core_req_ack[0]), 32'd1);
        chk("s1_rtr_req_c1", 32'(rtr_req[0]), 32'd0);
        tick(); core_req[0] = 1'b0; rtr_req_ack[0] = 1'b1;
        #1 chk("s1_rtr_req_c2", 32'(rtr_req[0]), 32'd1);
        chk("s1_rtr_addr", rtr_addr[0], 32'h0001_0004);
        tick(); rtr_req_ack[0] = 1'b0; rtr_resp[0] = OK; rtr_rdata[0] = 32'hDEAD_BEEF;
        #1 chk("s1_rtr_req_c3", 32'(rtr_req[0]), 32'd0);
        chk("s1_resp", 32'(core_resp[0]), 32'(OK));
        chk("s1_rdata", core_rdata[0], 32'hDEAD_BEEF);
        tick(); idle_inputs(0);
        #1 chk("s1_idle_resp", 32'(core_resp[0]), 32'(NR));

        // Router stall on a write; core-side fields change underneath
        tick(); offer(0, SCR1_MEM_CMD_WR, 32'h0000_0020, 32'h1234_5678);
        core_width[0] = SCR1_MEM_WIDTH_BYTE;
        for (int i = 0; i < 4; i++) begin
            tick(); core_req[0] = 1'b0; core_cmd[0] = SCR1_MEM_CMD_RD;
            core_addr[0] = 32'hFFFF_FFFC; core_wdata[0] = 32'hA5A5_A5A5;
            #1 chk("s2_rtr_req", 32'(rtr_req[0]), 32'd1);
            chk("s2_rtr_addr", rtr_addr[0], 32'h0000_0020);
            chk("s2_rtr_wdata", rtr_wdata[0], 32'h1234_5678);
            chk("s2_rtr_cmd", 32'(rtr_cmd[0]), 32'(SCR1_MEM_CMD_WR));
            chk("s2_no_ack", 32'(core_req_ack[0]), 32'd0);
        end
        tick(); rtr_req_ack[0] = 1'b1;
        #1 chk("s2_xfer", 32'(rtr_req[0]), 32'd1);
        tick(); rtr_req_ack[0] = 1'b0; rtr_resp[0] = OK;
        #1 chk("s2_single", 32'(rtr_req[0]), 32'd0);
        chk("s2_resp", 32'(core_resp[0]), 32'(OK));
        tick(); idle_inputs(0);

        // Back-to-back reads: responses at cycles 3, 5, 7 after first accept at cycle 1
        tick(); offer(0, SCR1_MEM_CMD_RD, 32'h0000_0100, 32'h0);
        #1 chk("s3_accept0", 32'(core_req_ack[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); rtr_req_ack[0] = 1'b1; rtr_resp[0] = NR;
            core_req[0] = (i < 2);
            core_addr[0] = 32'h0000_0104 + 32'(4 * i);
            #1 chk("s3_rtr_addr", rtr_addr[0], 32'h0000_0100 + 32'(4 * i));
            chk("s3_hold_ack", 32'(core_req_ack[0]), 32'd0);
            tick(); rtr_req_ack[0] = 1'b0; rtr_resp[0] = OK; rtr_rdata[0] = 32'h1111_0000 + 32'(i);
            #1 chk("s3_resp", 32'(core_resp[0]), 32'(OK));
            chk("s3_rdata", core_rdata[0], 32'h1111_0000 + 32'(i));
            chk("s3_accept_with_ok", 32'(core_req_ack[0]), 32'd1);
        end
        tick(); idle_inputs(0);
        #1 chk("s3_done", 32'(rtr_req[0]), 32'd0);

        // Error response with a new request offered in the same cycle
        tick(); offer(0, SCR1_MEM_CMD_RD, 32'h0000_0200, 32'h0);
        tick(); core_req[0] = 1'b0; rtr_req_ack[0] = 1'b1;
        tick(); rtr_req_ack[0] = 1'b0;
        #1 chk("s4_wait_resp", 32'(core_resp[0]), 32'(NR));
        chk("s4_wait_ack", 32'(core_req_ack[0]), 32'd0);
        tick(); rtr_resp[0] = ER; offer(0, SCR1_MEM_CMD_WR, 32'h0000_0300, 32'hCAFE_0001);
        #1 chk("s4_err_resp", 32'(core_resp[0]), 32'(ER));
        chk("s4_err_noack", 32'(core_req_ack[0]), 32'd0);
        tick(); rtr_resp[0] = NR;
        #1 chk("s4_idle_ack", 32'(core_req_ack[0]), 32'd1);
        chk("s4_idle_noreq", 32'(rtr_req[0]), 32'd0);
        tick(); core_req[0] = 1'b0; rtr_req_ack[0] = 1'b1;
        #1 chk("s4_req_addr", rtr_addr[0], 32'h0000_0300);
        chk("s4_req_wdata", rtr_wdata[0], 32'hCAFE_0001);
        tick(); rtr_req_ack[0] = 1'b0; rtr_resp[0] = OK;
        tick(); idle_inputs(0);

        // Registered response: same read as the first scenario
        tick(); offer(1, SCR1_MEM_CMD_RD, 32'h0001_0004, 32'h0);
        tick(); core_req[1] = 1'b0; rtr_req_ack[1] = 1'b1;
        #1 chk("s5_rtr_req", 32'(rtr_req[1]), 32'd1);
        tick(); rtr_req_ack[1] = 1'b0; rtr_resp[1] = OK; rtr_rdata[1] = 32'hDEAD_BEEF;
        #1 chk("s5_c3_resp", 32'(core_resp[1]), 32'(NR));
        tick(); rtr_resp[1] = NR; rtr_rdata[1] = 32'h0; offer(1, SCR1_MEM_CMD_RD, 32'h0000_0040, 32'h0);
        #1 chk("s5_c4_resp", 32'(core_resp[1]), 32'(OK));
        chk("s5_c4_rdata", core_rdata[1], 32'hDEAD_BEEF);
        chk("s5_c4_ack", 32'(core_req_ack[1]), 32'd1);
        tick(); core_req[1] = 1'b0; rtr_req_ack[1] = 1'b1;
        #1 chk("s5_b2b_addr", rtr_addr[1], 32'h0000_0040);
        tick(); rtr_req_ack[1] = 1'b0; rtr_resp[1] = ER;
        tick(); rtr_resp[1] = NR;
        #1 chk("s5_err_resp", 32'(core_resp[1]), 32'(ER));
        chk("s5_err_noack", 32'(core_req_ack[1]), 32'd0);
        tick(); idle_inputs(1);

        // Reset mid-transaction: dut0 in WAIT with a response showing, dut1 holding a request
        tick(); offer(0, SCR1_MEM_CMD_RD, 32'h0000_0500, 32'h0);
        offer(1, SCR1_MEM_CMD_WR, 32'h0000_0600, 32'h0000_0066);
        tick(); core_req[0] = 1'b0; core_req[1] = 1'b0; rtr_req_ack[0] = 1'b1;
        tick(); rtr_req_ack[0] = 1'b0; rtr_resp[0] = OK; rtr_rdata[0] = 32'h77;
        #1 chk("s6_pre_resp", 32'(core_resp[0]), 32'(OK));
        chk("s6_pre_req", 32'(rtr_req[1]), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("s6_rst_resp", 32'(core_resp[0]), 32'(NR));
        chk("s6_rst_ack", 32'(core_req_ack[0]), 32'd1);
        chk("s6_rst_rtr_req", 32'(rtr_req[1]), 32'd0);
        chk("s6_rst_addr", rtr_addr[1], 32'h0);
        idle_inputs(0);
        tick(); tick(); rst_n = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("s6_post_cmd", 32'(rtr_cmd[d]), 32'(SCR1_MEM_CMD_RD));
            chk("s6_post_wdata", rtr_wdata[d], 32'h0);
            chk("s6_post_ack", 32'(core_req_ack[d]), 32'd1);
        end
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_slice.md
# scr1_dmem_slice

Single-entry pipeline slice on the data memory path, between the core's dmem interface and the dmem router. It registers the request (cmd, width, addr, wdata) so the router's address decode and port selection start from flops rather than core logic. It also removes the combinational path from router/port `req_ack` back into the core. An optional response register breaks the `rdata`/`resp` return path at the cost of one cycle.

## Interface
Parameters:
- `SCR1_SLICE_RESP_REG`, default 0. 0: response passes through combinationally. 1: response is registered (+1 cycle).

Ports (`type_*` are the standard SCR1 memory-interface enums):
- `rst_n` input 1: reset, asynchronous, active-low.
- `clk` input 1: the block's single clock.
- `core_req_ack` output 1: request accepted from the core.
- `core_req` input 1: core request valid.
- `core_cmd` input `type_scr1_mem_cmd_e`: read/write.
- `core_width` input `type_scr1_mem_width_e`: access width.
- `core_addr` input `SCR1_DMEM_AWIDTH`: address.
- `core_wdata` input `SCR1_DMEM_DWIDTH`: write data.
- `core_rdata` output `SCR1_DMEM_DWIDTH`: read data to the core.
- `core_resp` output `type_scr1_mem_resp_e`: response to the core.
- `rtr_req_ack` input 1: router accepted the request.
- `rtr_req` output 1: request to the router.
- `rtr_cmd`, `rtr_width`, `rtr_addr`, `rtr_wdata` outputs: registered request fields.
- `rtr_rdata` input `SCR1_DMEM_DWIDTH`: read data from the router.
- `rtr_resp` input `type_scr1_mem_resp_e`: response from the router.

## Operation
State machine states:
- `IDLE`: nothing held.
- `REQ`: request held, `rtr_req`=1.
- `WAIT`: accepted downstream, awaiting response.
- `RSP`: only when `SCR1_SLICE_RESP_REG`=1; registered response presented.

Transitions:
- `IDLE`: `core_req_ack`=1. If `core_req`=1, capture the request fields and go to `REQ`.
- `REQ`: `rtr_req`=1 with the held fields, which stay stable until acked. `core_req_ack`=0 and `core_resp`=`NOTRDY`. When `rtr_req_ack`=1, go to `WAIT`.
- `WAIT` with `SCR1_SLICE_RESP_REG`=0:
  - `core_resp`=`rtr_resp` and `core_rdata`=`rtr_rdata`.
  - `core_req_ack`=(`rtr_resp`==`RDY_OK`).
  - On `RDY_OK` with `core_req`=1: capture the new request and go to `REQ` (back-to-back accept).
  - On `RDY_OK` with no `core_req`: go to `IDLE`.
  - On `RDY_ER`: go to `IDLE`; no request is accepted in that cycle.
  - On `NOTRDY`: stay in `WAIT`.
- `WAIT` with `SCR1_SLICE_RESP_REG`=1:
  - `core_resp`=`NOTRDY` and `core_req_ack`=0.
  - On `rtr_resp`≠`NOTRDY`: capture `rtr_resp` into `resp_r` and `rtr_rdata` into `rdata_r`, then go to `RSP`.
- `RSP`:
  - `core_resp`=`resp_r` and `core_rdata`=`rdata_r`.
  - `core_req_ack`=(`resp_r`==`RDY_OK`).
  - Next state follows the same rules as `WAIT` in mode 0, using `resp_r` in place of `rtr_resp`.

Other rules:
- Write data is captured unconditionally with the request; `rdata` is meaningful only for reads.
- Ordering is strictly in-order; at most one request is in flight.
- Under `SCR1_XPROP_EN`: `core_rdata`=`'x` whenever `core_resp`=`NOTRDY`.
- Under `SCR1_TRGT_SIMULATION`, SVA checks:
  - `core_req` implies `core_cmd` and `core_width` are known.
  - `rtr_req` implies `rtr_*` fields are stable until `rtr_req_ack`.

## Timing
- Reset values:
  - state `IDLE`; `rtr_req`=0.
  - `rtr_cmd`=`SCR1_MEM_CMD_RD`, `rtr_width`=`SCR1_MEM_WIDTH_WORD`; `rtr_addr` and `rtr_wdata`=0.
  - `core_resp`=`NOTRDY` and `core_req_ack`=1.
  - `resp_r`=`NOTRDY` and `rdata_r`=0.
- Latency, core accept at cycle N:
  - `rtr_req` asserts at N+1.
  - With immediate router ack and a one-cycle response, `core_resp` is valid at N+2 (mode 0) or N+3 (mode 1).
- Throughput: one transaction per 2 cycles (mode 0) or 3 cycles (mode 1) with a zero-wait downstream.
- No combinational path from `rtr_req_ack` to `core_req_ack`. Mode 1 also has no combinational path from `rtr_resp`/`rtr_rdata` to the core outputs.
- Reset mid-transaction: state returns to `IDLE` immediately and `rtr_req` drops asynchronously. Any in-flight response is discarded.

## Test plan
- Single read, mode 0:
  - Stimulus: `core_req` at cycle 1, addr 0x00010004; router acks in cycle 2 and returns `RDY_OK`, rdata 0xDEADBEEF in cycle 3.
  - Required: `rtr_req`=1 in cycle 2 only; `core_resp`=`RDY_OK` and `core_rdata`=0xDEADBEEF in cycle 3.
- Router stall:
  - Stimulus: `rtr_req_ack` held 0 for 4 cycles on a write of wdata 0x12345678.
  - Required: `rtr_addr`, `rtr_wdata` and `rtr_cmd` stay stable; `core_req_ack`=0 throughout; a single transfer on ack.
- Back-to-back:
  - Stimulus: `core_req` held for 3 reads.
  - Required: the second accept coincides with the first `RDY_OK`; 3 responses in order within 6 cycles (mode 0).
- Error response:
  - Stimulus: `rtr_resp`=`RDY_ER` with `core_req`=1 in the same cycle.
  - Required: `core_resp`=`RDY_ER`, `core_req_ack`=0, next state `IDLE`; the new request is accepted one cycle later.
- Mode 1:
  - Stimulus: repeat the first scenario with `SCR1_SLICE_RESP_REG`=1.
  - Required: `core_resp`=`RDY_OK` at cycle 4 with the registered data.
- Reset mid-transaction:
  - Stimulus: assert `rst_n`=0 while in `WAIT`.
  - Required: `rtr_req`=0 and `core_resp`=`NOTRDY` immediately; after release, `IDLE` with all reset values.
